systolic_ctrl: RTL

Sequencer in front of the N×N weight-stationary `array` block.
- Accepts a weight-row stream and preloads the weights by driving `load` for N rows.
- Streams activation rows into the array with a per-lane diagonal skew.
- Captures and deskews `array_output` into aligned result rows, then drains the pipeline and signals completion.
- Sits between the DMA/buffer side (valid/ready streams) and the `array` datapath.

---
 rtl/systolic_pkg.sv | 14 +
 rtl/skew_line.sv | 36 +++
 rtl/systolic_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared dimensions, row/state types and lane helper for the systolic sequencer
`timescale 1ns/1ps
package systolic_pkg;
  localparam int N = 8;
  localparam int DW = 8;
  localparam int OUT_LAT = 8;
  localparam int WCW = $clog2(N + 1);
  typedef logic [N*DW-1:0] row_t;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  // bit position of the LSB of lane k in an n-lane row; lane 0 is the most significant lane
  function automatic int lane_lsb(input int k, input int n, input int dw);
    return dw * (n - 1 - k);
  endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: per-lane delay line; SKEW=1 delays lane k by k cycles, SKEW=0 delays lane k by N-1-k
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   d          : N*DW input row
//   q          : N*DW delayed row (zero-delay lanes are combinational)
`timescale 1ns/1ps
module skew_line #(
  parameter int N = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW,
  parameter bit SKEW = 1'b1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [N*DW-1:0] d,
  output logic [N*DW-1:0] q
);
  import systolic_pkg::*;
  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int D = SKEW ? k : N - 1 - k;
    localparam int L = lane_lsb(k, N, DW);
    if (D == 0) begin : g_wire
      assign q[L +: DW] = d[L +: DW];
    end else begin : g_reg
      logic [DW-1:0] sr [D];
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= d[L +: DW];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign q[L +: DW] = sr[D-1];
    end
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight preload, skewed activation streaming and result deskew for an NxN weight-stationary array
// Ports:
//   clk, n_rst              : clock, asynchronous active-low reset
//   start, num_rows         : job start (IDLE only) and activation row count
//   w_data/w_valid/w_ready  : weight row stream (N rows per job)
//   x_data/x_valid/x_ready  : activation row stream
//   y_data/y_valid          : deskewed result rows, no backpressure
//   busy, done              : job in progress, one-cycle completion pulse
//   load, array_input       : to array (weight strobe / lane data)
//   array_output            : from array
// Optional: SYSTOLIC_CTRL_PERF_EN adds perf_cycles (busy cycles) and perf_bubbles (idle STREAM cycles).
`timescale 1ns/1ps
module systolic_ctrl
  import systolic_pkg::*;
(
  input  logic            clk,
  input  logic            n_rst,
  input  logic            start,
  input  logic [15:0]     num_rows,
  input  logic [N*DW-1:0] w_data,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] x_data,
  input  logic            x_valid,
  output logic            x_ready,
  output logic [N*DW-1:0] y_data,
  output logic            y_valid,
  output logic            busy,
  output logic            done,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_bubbles,
`endif
  output logic            load,
  output logic [N*DW-1:0] array_input,
  input  logic [N*DW-1:0] array_output
);
  // tag travels from acceptance to the y register: N skew/deskew stages plus OUT_LAT in the array
  localparam int TL = N + OUT_LAT;
  state_t         state;
  logic [15:0]    rows;
  logic [15:0]    x_cnt;
  logic [WCW-1:0] w_cnt;
  logic [TL-1:0]  tags;
  row_t           skew_d;
  row_t           skew_q;
  row_t           desk_q;
  logic           w_hs;
  logic           x_hs;
  assign w_hs = w_valid & w_ready;
  assign x_hs = x_valid & x_ready;
  // bubbles enter as zero rows so the array sees nothing between real rows
  assign skew_d = x_hs ? x_data : '0;
  skew_line #(.N(N), .DW(DW), .SKEW(1'b1)) u_skew (
    .clk(clk), .n_rst(n_rst), .d(skew_d), .q(skew_q)
  );
  skew_line #(.N(N), .DW(DW), .SKEW(1'b0)) u_deskew (
    .clk(clk), .n_rst(n_rst), .d(array_output), .q(desk_q)
  );
  // LOAD_W lingers one cycle after the N-th handshake so the final load strobe stays inside LOAD_W
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      rows    <= '0;
      x_cnt   <= '0;
      w_cnt   <= '0;
      w_ready <= 1'b0;
      x_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= LOAD_W;
          rows    <= num_rows;
          w_cnt   <= '0;
          x_cnt   <= '0;
          w_ready <= 1'b1;
          busy    <= 1'b1;
        end
        LOAD_W: if (w_cnt == WCW'(N)) begin
          state   <= (rows == 16'd0) ? DONE : STREAM;
          x_ready <= rows != 16'd0;
          done    <= rows == 16'd0;
        end else if (w_hs) begin
          w_cnt   <= w_cnt + 1'b1;
          w_ready <= w_cnt != WCW'(N - 1);
        end
        STREAM: if (x_hs) begin
          x_cnt <= x_cnt + 1'b1;
          if (x_cnt == rows - 16'd1) begin
            state   <= DRAIN;
            x_ready <= 1'b0;
          end
        end
        DRAIN: if (tags == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // skew line is empty outside STREAM/DRAIN, so it contributes zeros during weight loading
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      load        <= 1'b0;
      array_input <= '0;
      tags        <= '0;
      y_valid     <= 1'b0;
      y_data      <= '0;
    end else begin
      load        <= w_hs;
      array_input <= w_hs ? w_data : skew_q;
      tags        <= {tags[TL-2:0], x_hs};
      y_valid     <= tags[TL-1];
      y_data      <= tags[TL-1] ? desk_q : '0;
    end
  end
`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
      if (x_ready && !x_valid && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 1'b1;
    end
  end
`endif
endmodule
